// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state type for the round-robin arbiter
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
// Returns the first set request searching upward from i_last_id+1, wrapping modulo N.
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_last_id,
    output logic [IDW-1:0] o_sel,
    output logic           o_valid
);

    always_comb begin
        int w_idx;
        w_idx   = 0;
        o_sel   = '0;
        o_valid = |i_req;
        // Walk from the farthest candidate to the nearest so the nearest set bit wins.
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(i_last_id) + k) % N;
            if (i_req[w_idx[IDW-1:0]]) begin
                o_sel = w_idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant and hold timeout
// A grant lasts until the owner drops its request or MAX_HOLD cycles elapse.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    localparam int HCW = $clog2(MAX_HOLD + 1);

    arb_state_t     r_state,   w_state_nxt;
    logic [N-1:0]   r_gnt,     w_gnt_nxt;
    logic [IDW-1:0] r_gnt_id,  w_gnt_id_nxt;
    logic           r_busy,    w_busy_nxt;
    logic           r_timeout, w_timeout_nxt;
    logic [HCW-1:0] r_hold,    w_hold_nxt;
    logic [IDW-1:0] r_last_id, w_last_id_nxt;

    logic [IDW-1:0] w_sel;
    logic           w_valid;

    rr_pick #(.N(N)) u_pick (
        .i_req     (req),
        .i_last_id (r_last_id),
        .o_sel     (w_sel),
        .o_valid   (w_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_hold    <= '0;
            r_last_id <= IDW'(N - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_hold    <= w_hold_nxt;
            r_last_id <= w_last_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        w_hold_nxt    = r_hold;
        w_last_id_nxt = r_last_id;

        case (r_state)
            IDLE: begin
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
                w_busy_nxt   = 1'b0;
                w_hold_nxt   = '0;
                if (w_valid) begin
                    w_state_nxt   = OWNED;
                    w_gnt_nxt     = {{(N-1){1'b0}}, 1'b1} << w_sel;
                    w_gnt_id_nxt  = w_sel;
                    w_busy_nxt    = 1'b1;
                    w_hold_nxt    = HCW'(1);
                    w_last_id_nxt = w_sel;
                end
            end
            OWNED: begin
                // Release takes precedence over timeout when both happen on one edge.
                if (!req[r_gnt_id] || (r_hold == HCW'(MAX_HOLD))) begin
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = '0;
                    w_gnt_id_nxt  = '0;
                    w_busy_nxt    = 1'b0;
                    w_hold_nxt    = '0;
                    w_timeout_nxt = req[r_gnt_id];
                end else begin
                    w_hold_nxt = r_hold + HCW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
